cnn_load_sequencer: RTL
=======================

// Module: cnn_load_sequencer
// PURPOSE
//  Sequences host word writes into the CNN accelerator's on-chip memories: image banks 0-3, then conv weight RAM, then dense weight RAM.
//  Sits between the Avalon slave register file and the image/conv/dense RAM write ports.
//  Generates the write enables, addresses and byte data for each memory.
//  Signals load completion and issues a one-cycle start pulse to the compute engine.
// PARAMETERS
//  IMG_WORDS    196    32-bit image words; each word writes 1 byte to each of banks 0-3 at the same address
//  CONV_BYTES   55744  conv weight bytes; one byte per host write, taken from wr_data[7:0]
//  DENSE_BYTES  37578  dense weight bytes; one byte per host write, taken from wr_data[7:0]
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  cmd_start     in   1   begin load sequence (honoured only in IDLE)
//  cmd_abort     in   1   abandon sequence, return to IDLE
//  wr_valid      in   1   host write strobe, one transfer per high cycle
//  wr_data       in   32  host write data
//  wren0..wren3  out  1   image bank write enables
//  data0..data3  out  8   image bank data: data0=wr_data[31:24] .. data3=wr_data[7:0]
//  image_addr    out  10  image bank address
//  wren_conv     out  1   conv RAM write enable
//  conv_addr     out  16  conv RAM address
//  conv_data     out  8   conv RAM data
//  wren_dense    out  1   dense RAM write enable
//  dense_addr    out  16  dense RAM address
//  dense_data    out  8   dense RAM data
//  phase         out  2   0=IDLE/DONE, 1=IMG, 2=CONV, 3=DENSE
//  load_done     out  1   high while in DONE
//  compute_start out  1   1-cycle pulse on entry to DONE
//  overflow_err  out  1   sticky: wr_valid received outside a load phase
//  checksum      out  16  running byte sum (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; every output, counter and the checksum is 0.
//  FSM: IDLE -cmd_start-> IMG -last-> CONV -last-> DENSE -last-> DONE -cmd_start-> IMG.
//  On leaving IDLE or DONE via cmd_start: counter, overflow_err and checksum clear.
//  Counter: single 16-bit cnt, reset to 0 on each phase entry.
//   - "last" = wr_valid while cnt == N-1, where N is the phase count parameter.
//   - On "last" the FSM advances; cnt never exceeds N-1.
//  Write path, 1-cycle latency: wr_valid in cycle t drives the following in cycle t+1:
//   - the enable(s) for the current phase, high for exactly one cycle
//   - addr = cnt value sampled at t
//   - data registered from wr_data at t
//  IMG phase: wren0..3 all assert together; all four banks share image_addr.
//  Enables deassert when wr_valid is low; address and data outputs hold their last value.
//  Back-to-back wr_valid is supported: one write per cycle, no gaps and no stalls.
//  Phase boundary: the "last" write belongs to the old phase.
//   - The next cycle's wr_valid goes to the new phase at addr 0.
//  wr_valid in IDLE or DONE: no enable asserts; overflow_err sets the next cycle and holds.
//  cmd_abort (any state): next state IDLE, cnt=0.
//   - Abort takes priority over a same-cycle wr_valid: no write is issued.
//   - RAM contents are left as written.
//  cmd_start and cmd_abort in the same cycle: abort wins.
//  cmd_start outside IDLE/DONE: ignored.
//  Reset mid-sequence: same as power-on reset. A pending registered write is dropped.
//  compute_start asserts exactly one cycle, in the first DONE cycle.
//  load_done holds until cmd_start, cmd_abort or reset.
// CONFIGURATION
//  CNN_LOAD_CHECKSUM_EN defined:
//   - checksum = sum mod 2^16 of every byte actually written this sequence.
//   - IMG phase adds all 4 bytes of the word; CONV/DENSE add the 1 byte written.
//   - Updates in the same cycle as the write enable.
//  CNN_LOAD_CHECKSUM_EN not defined: checksum is constant 0, and no adder logic is generated.
// TESTING
//  Bench build uses IMG_WORDS=4, CONV_BYTES=6, DENSE_BYTES=5. Checksum scenario runs with CNN_LOAD_CHECKSUM_EN defined.
//  1 Full load:
//    - stimulus: cmd_start, then 15 back-to-back writes
//    - IMG: image_addr 0..3, wren0-3 high
//    - CONV: conv_addr 0..5; DENSE: dense_addr 0..4
//    - compute_start pulses once, 1 cycle after the last write; load_done=1
//  2 Byte lanes:
//    - IMG write 0xA1B2C3D4 -> data0=A1, data1=B2, data2=C3, data3=D4
//    - CONV write 0xFFFFFF5A -> conv_data=5A
//  3 Gapped writes:
//    - wr_valid high every 3rd cycle -> enables pulse 1 cycle each
//    - addresses increment once per write; phase counts unaffected
//  4 Abort:
//    - cmd_abort together with wr_valid at CONV cnt=2 -> no wren_conv, next phase=0
//    - cmd_start then restarts at image_addr 0
//  5 Overflow:
//    - wr_valid in IDLE -> no enables, overflow_err=1
//    - overflow_err held through DONE, cleared by the next cmd_start
//  6 Checksum:
//    - run scenario 1 with all bytes 0x01 -> checksum = 16+6+5 = 27
//    - mid-run reset -> checksum=0, state IDLE

Source files
------------

// File: rtl/cnn_load_sequencer.sv
// cnn_load_sequencer: steers host word writes into image banks 0-3, then conv
// weight RAM, then dense weight RAM, and pulses compute_start once the load completes.
// Latency: one cycle from wr_valid to the RAM write enable. Never stalls the host:
// every wr_valid cycle is taken. Optional build macro CNN_LOAD_CHECKSUM_EN adds a running byte checksum.
module cnn_load_sequencer #(
  parameter int IMG_WORDS   = 196,
  parameter int CONV_BYTES  = 55744,
  parameter int DENSE_BYTES = 37578
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wren0,
  output logic        wren1,
  output logic        wren2,
  output logic        wren3,
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [7:0]  data3,
  output logic [9:0]  image_addr,
  output logic        wren_conv,
  output logic [15:0] conv_addr,
  output logic [7:0]  conv_data,
  output logic        wren_dense,
  output logic [15:0] dense_addr,
  output logic [7:0]  dense_data,
  output logic [1:0]  phase,
  output logic        load_done,
  output logic        compute_start,
  output logic        overflow_err,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMG,
    S_CONV,
    S_DENSE,
    S_DONE
  } state_t;

  localparam logic [15:0] IMG_LAST   = 16'(IMG_WORDS - 1);
  localparam logic [15:0] CONV_LAST  = 16'(CONV_BYTES - 1);
  localparam logic [15:0] DENSE_LAST = 16'(DENSE_BYTES - 1);

  state_t      state;
  logic [15:0] cnt;

  // Sequencer FSM: phase tracking, per-phase write counter and registered RAM write ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 16'h0000;
      wren0         <= 1'b0;
      wren1         <= 1'b0;
      wren2         <= 1'b0;
      wren3         <= 1'b0;
      data0         <= 8'h00;
      data1         <= 8'h00;
      data2         <= 8'h00;
      data3         <= 8'h00;
      image_addr    <= 10'h000;
      wren_conv     <= 1'b0;
      conv_addr     <= 16'h0000;
      conv_data     <= 8'h00;
      wren_dense    <= 1'b0;
      dense_addr    <= 16'h0000;
      dense_data    <= 8'h00;
      phase         <= 2'd0;
      load_done     <= 1'b0;
      compute_start <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      // Enables and the start pulse are single-cycle; address/data hold their last value.
      wren0         <= 1'b0;
      wren1         <= 1'b0;
      wren2         <= 1'b0;
      wren3         <= 1'b0;
      wren_conv     <= 1'b0;
      wren_dense    <= 1'b0;
      compute_start <= 1'b0;
      if (cmd_abort) begin
        // Abort beats any same-cycle start or write; RAM contents are left alone.
        state     <= S_IDLE;
        cnt       <= 16'h0000;
        phase     <= 2'd0;
        load_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (cmd_start) begin
              state        <= S_IMG;
              cnt          <= 16'h0000;
              phase        <= 2'd1;
              load_done    <= 1'b0;
              overflow_err <= 1'b0;
            end else if (wr_valid) begin
              overflow_err <= 1'b1;
            end
          end
          S_IMG: begin
            if (wr_valid) begin
              wren0      <= 1'b1;
              wren1      <= 1'b1;
              wren2      <= 1'b1;
              wren3      <= 1'b1;
              image_addr <= cnt[9:0];
              data0      <= wr_data[31:24];
              data1      <= wr_data[23:16];
              data2      <= wr_data[15:8];
              data3      <= wr_data[7:0];
              if (cnt == IMG_LAST) begin
                state <= S_CONV;
                cnt   <= 16'h0000;
                phase <= 2'd2;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          S_CONV: begin
            if (wr_valid) begin
              wren_conv <= 1'b1;
              conv_addr <= cnt;
              conv_data <= wr_data[7:0];
              if (cnt == CONV_LAST) begin
                state <= S_DENSE;
                cnt   <= 16'h0000;
                phase <= 2'd3;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          S_DENSE: begin
            if (wr_valid) begin
              wren_dense <= 1'b1;
              dense_addr <= cnt;
              dense_data <= wr_data[7:0];
              if (cnt == DENSE_LAST) begin
                state         <= S_DONE;
                cnt           <= 16'h0000;
                phase         <= 2'd0;
                load_done     <= 1'b1;
                compute_start <= 1'b1;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= 16'h0000;
            phase <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef CNN_LOAD_CHECKSUM_EN
  logic        in_load;
  logic [15:0] wr_sum;
  logic [15:0] csum;

  // Bytes carried by the current host write: four lanes in IMG, low byte otherwise.
  always_comb begin
    in_load = (state == S_IMG) || (state == S_CONV) || (state == S_DENSE);
    wr_sum  = {8'h00, wr_data[7:0]};
    if (state == S_IMG) begin
      wr_sum = 16'(wr_data[31:24]) + 16'(wr_data[23:16])
             + 16'(wr_data[15:8])  + 16'(wr_data[7:0]);
    end
  end

  // Running checksum, registered alongside the write enables so both appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= 16'h0000;
    end else if (!cmd_abort) begin
      if (((state == S_IDLE) || (state == S_DONE)) && cmd_start) begin
        csum <= 16'h0000;
      end else if (in_load && wr_valid) begin
        csum <= csum + wr_sum;
      end
    end
  end

  assign checksum = csum;
`else
  assign checksum = 16'h0000;
`endif

endmodule
